// File: rtl/word_packer_256.sv
// ---------------------------------------------------------------------------
// word_packer_256
//
// Packs a stream of 16-bit words into 256-bit bus words for the variable-size
// word FIFO downstream. Up to 16 input words are gathered into one bus word.
// The packed word is written out in a single FIFO write when:
//   - all 16 slots are filled,
//   - the source marks the end of a burst with in_last, or
//   - the input has been idle for TIMEOUT cycles while a partial word is held.
// The FIFO full flag is honoured: a pending write waits, with all outputs
// held, until full drops.
//
// Parameters:
//   TIMEOUT   idle cycles with a partial word before a forced flush; 0 = off
//
// Ports:
//   clk        in   1    clock, rising edge
//   reset_p    in   1    asynchronous active-high reset
//   in_data    in   16   input word
//   in_valid   in   1    in_data is valid
//   in_last    in   1    word ends a burst (qualified by in_valid)
//   in_ready   out  1    packer accepts a word this cycle
//   data_o     out  256  packed word, word k at bits [k*16+15:k*16]
//   size_o     out  4    number of valid words on data_o, 0 encodes 16
//   data_we    out  1    write data_o/size_o into the FIFO this cycle
//   full       in   1    FIFO full, blocks data_we
//   flush_cnt  out  16   completed writes, wraps modulo 2^16
// ---------------------------------------------------------------------------
module word_packer_256 #(
    parameter int TIMEOUT = 32
) (
    input  logic         clk,
    input  logic         reset_p,
    input  logic [15:0]  in_data,
    input  logic         in_valid,
    input  logic         in_last,
    output logic         in_ready,
    output logic [255:0] data_o,
    output logic [3:0]   size_o,
    output logic         data_we,
    input  logic         full,
    output logic [15:0]  flush_cnt
);

    typedef enum logic {
        ST_COLLECT = 1'b0,
        ST_FLUSH   = 1'b1
    } state_t;

    // idle_cnt value at which the forced flush fires; unused when TIMEOUT=0.
    localparam logic [15:0] IDLE_LIMIT = (TIMEOUT > 0) ? 16'(TIMEOUT - 1) : 16'd0;
    localparam bit          TIMEOUT_EN = (TIMEOUT > 0);

    state_t      state_q, state_d;
    logic [4:0]  word_idx_q, word_idx_d;
    logic [15:0] idle_cnt_q, idle_cnt_d;
    logic [15:0] flush_cnt_q, flush_cnt_d;

    logic accept;
    logic last_slot;
    logic timeout_hit;

    // in_ready is forced low while reset is held, not only after the flops
    // settle, so no word can be handshaked during reset.
    assign in_ready    = (state_q == ST_COLLECT) && !reset_p;
    assign accept      = in_valid && in_ready;
    assign data_we     = (state_q == ST_FLUSH) && !full;
    assign last_slot   = (word_idx_q == 5'd15);
    assign timeout_hit = TIMEOUT_EN && (word_idx_q != 5'd0) && !accept
                         && (idle_cnt_q == IDLE_LIMIT);

    assign size_o    = word_idx_q[3:0];
    assign flush_cnt = flush_cnt_q;

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            state_q     <= ST_COLLECT;
            word_idx_q  <= 5'd0;
            idle_cnt_q  <= 16'd0;
            flush_cnt_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            word_idx_q  <= word_idx_d;
            idle_cnt_q  <= idle_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        word_idx_d  = word_idx_q;
        idle_cnt_d  = idle_cnt_q;
        flush_cnt_d = flush_cnt_q;

        case (state_q)
            ST_COLLECT: begin
                if (accept) begin
                    word_idx_d = word_idx_q + 5'd1;
                    idle_cnt_d = 16'd0;
                    // The 16th word and in_last both end the bus word; when they
                    // coincide this is still a single transition, hence one write.
                    if (last_slot || in_last) begin
                        state_d = ST_FLUSH;
                    end
                end else if (word_idx_q != 5'd0) begin
                    if (timeout_hit) begin
                        state_d = ST_FLUSH;
                    end
                    if (idle_cnt_q != 16'hFFFF) begin
                        idle_cnt_d = idle_cnt_q + 16'd1;
                    end
                end else begin
                    // Nothing buffered: idle time is meaningless, keep it at 0.
                    idle_cnt_d = 16'd0;
                end
            end

            ST_FLUSH: begin
                idle_cnt_d = 16'd0;
                if (data_we) begin
                    state_d     = ST_COLLECT;
                    word_idx_d  = 5'd0;
                    flush_cnt_d = flush_cnt_q + 16'd1;
                end
            end

            default: begin
                state_d = ST_COLLECT;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Slot registers. Each slot is cleared when the write completes, so slots
    // above size_o always read back as zero on data_o.
    // -----------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_slot
            logic [15:0] slot_q;
            logic        wr_en;

            // word_idx never exceeds 15 in COLLECT, so the low 4 bits select
            // the slot directly.
            assign wr_en = accept && (word_idx_q[3:0] == 4'(gi));

            always_ff @(posedge clk or posedge reset_p) begin
                if (reset_p) begin
                    slot_q <= 16'd0;
                end else if (data_we) begin
                    slot_q <= 16'd0;
                end else if (wr_en) begin
                    slot_q <= in_data;
                end
            end

            assign data_o[gi*16 +: 16] = slot_q;
        end
    endgenerate

endmodule

// File: tb/tb_word_packer_256.sv
module tb_word_packer_256;

    typedef struct {
        logic [255:0] d;
        logic [3:0]   s;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset_p = 1'b1;
    logic [15:0]  in_data = '0;
    logic         in_valid = 1'b0;
    logic         in_last = 1'b0;
    logic         in_ready;
    logic [255:0] data_o;
    logic [3:0]   size_o;
    logic         data_we;
    logic         full;
    logic         full_dir = 1'b0;
    logic         full_rnd = 1'b0;
    logic         rnd_en = 1'b0;
    logic [15:0]  flush_cnt;

    // Second instance with the timeout disabled.
    logic [15:0]  z_data = '0;
    logic         z_valid = 1'b0;
    logic         z_last = 1'b0;
    logic         z_ready;
    logic [255:0] z_data_o;
    logic [3:0]   z_size;
    logic         z_we;
    logic [15:0]  z_cnt;

    int checks = 0;
    int failures = 0;
    int wr_seen = 0;

    exp_t        exp_q[$];
    logic [15:0] cur[$];

    assign full = full_dir | full_rnd;

    always #5 clk = ~clk;

    word_packer_256 #(.TIMEOUT(4)) dut (
        .clk(clk), .reset_p(reset_p), .in_data(in_data), .in_valid(in_valid),
        .in_last(in_last), .in_ready(in_ready), .data_o(data_o), .size_o(size_o),
        .data_we(data_we), .full(full), .flush_cnt(flush_cnt)
    );

    word_packer_256 #(.TIMEOUT(0)) dut0 (
        .clk(clk), .reset_p(reset_p), .in_data(z_data), .in_valid(z_valid),
        .in_last(z_last), .in_ready(z_ready), .data_o(z_data_o), .size_o(z_size),
        .data_we(z_we), .full(1'b0), .flush_cnt(z_cnt)
    );

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end else begin
            $display("ok   %s = %h", name, act);
        end
    endtask

    // Reference model: a bus word is simply the collected words laid out
    // from slot 0 upward, with the count modulo 16 as the size code.
    function automatic exp_t pack(input logic [15:0] w[$]);
        exp_t e;
        e.d = '0;
        foreach (w[i]) e.d[i*16 +: 16] = w[i];
        e.s = 4'(w.size());
        return e;
    endfunction

    task automatic model_close();
        if (cur.size() > 0) begin
            exp_q.push_back(pack(cur));
            cur.delete();
        end
    endtask

    task automatic model_add(input logic [15:0] d, input logic l);
        cur.push_back(d);
        if (cur.size() == 16 || l) model_close();
    endtask

    // Present one word and wait for its handshake; returns #1 after the
    // accepting edge. Called #1 after a rising edge.
    task automatic send(input logic [15:0] d, input logic l);
        int n = 0;
        in_data = d; in_valid = 1'b1; in_last = l;
        while (!in_ready && n < 200) begin
            @(posedge clk); #1; n++;
        end
        if (n >= 200) begin
            checks++; failures++;
            $display("FAIL send_wait actual=in_ready_low required=accept_within_200");
        end
        @(posedge clk); #1;
        in_valid = 1'b0; in_last = 1'b0;
        model_add(d, l);
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // Scoreboard monitor: every write is compared against the oldest
    // expected bus word, and flush_cnt against the writes seen before it.
    initial begin
        forever begin
            @(negedge clk);
            if (reset_p) begin
                wr_seen = 0;
            end else if (data_we) begin
                if (exp_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_write actual=size%0d data=%h required=no_write", size_o, data_o);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("wr_data", data_o, e.d);
                    chk("wr_size", 256'(size_o), 256'(e.s));
                    chk("wr_flush_cnt", 256'(flush_cnt), 256'(16'(wr_seen)));
                end
                wr_seen++;
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk); #1;
            full_rnd = rnd_en && ($urandom_range(0, 3) == 0);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [255:0] bp_exp;
        int zw;

        // Reset state
        idle(2);
        chk("ready_in_reset", 256'(in_ready), 256'(0));
        reset_p = 1'b0;
        idle(1);
        chk("rst_ready", 256'(in_ready), 256'(1));
        chk("rst_we", 256'(data_we), 256'(0));
        chk("rst_size", 256'(size_o), 256'(0));
        chk("rst_data", data_o, 256'(0));
        chk("rst_cnt", 256'(flush_cnt), 256'(0));

        // Full word: 0x0001..0x0010
        for (int i = 1; i <= 16; i++) send(16'(i), 1'b0);
        chk("full_we_latency", 256'(data_we), 256'(1));
        chk("full_ready_low", 256'(in_ready), 256'(0));
        chk("full_lo_word", 256'(data_o[15:0]), 256'(16'h0001));
        chk("full_hi_word", 256'(data_o[255:240]), 256'(16'h0010));
        idle(1);
        chk("full_ready_back", 256'(in_ready), 256'(1));
        chk("full_cnt", 256'(flush_cnt), 256'(1));

        // Last marker
        send(16'h000A, 1'b0); send(16'h000B, 1'b0); send(16'h000C, 1'b1);
        chk("last_we", 256'(data_we), 256'(1));
        chk("last_size", 256'(size_o), 256'(3));
        chk("last_data", data_o, 256'(48'h000C_000B_000A));
        idle(1);

        // Timeout: flush entered TIMEOUT edges after the last accept
        send(16'h1111, 1'b0); send(16'h2222, 1'b0);
        model_close();
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk); #1;
            chk($sformatf("timeout_we_edge%0d", k), 256'(data_we), 256'(k == 4));
        end
        chk("timeout_size", 256'(size_o), 256'(2));
        idle(1);

        // Backpressure: full already high when FLUSH is entered
        full_dir = 1'b1;
        send(16'h0BB1, 1'b0); send(16'h0BB2, 1'b0); send(16'h0BB3, 1'b1);
        bp_exp = 256'(48'h0BB3_0BB2_0BB1);
        for (int k = 0; k < 10; k++) begin
            chk("bp_we_low", 256'(data_we), 256'(0));
            chk("bp_ready_low", 256'(in_ready), 256'(0));
            chk("bp_data_hold", data_o, bp_exp);
            chk("bp_size_hold", 256'(size_o), 256'(3));
            idle(1);
        end
        full_dir = 1'b0;
        #1;
        chk("bp_we_release", 256'(data_we), 256'(1));
        @(posedge clk); #1;
        chk("bp_ready_back", 256'(in_ready), 256'(1));
        chk("bp_we_single", 256'(data_we), 256'(0));
        chk("bp_cnt", 256'(flush_cnt), 256'(4));

        // in_last on the 16th word: exactly one write
        for (int i = 0; i < 16; i++) send(16'($urandom), i == 15);
        chk("l16_size", 256'(size_o), 256'(0));
        idle(3);
        chk("l16_cnt", 256'(flush_cnt), 256'(5));
        chk("l16_no_extra", 256'(exp_q.size()), 256'(0));

        // Asynchronous reset mid-operation
        for (int i = 0; i < 7; i++) send(16'(16'h0700 + i), 1'b0);
        #2;
        reset_p = 1'b1;
        #1;
        cur.delete();
        exp_q.delete();
        chk("arst_data", data_o, 256'(0));
        chk("arst_size", 256'(size_o), 256'(0));
        chk("arst_we", 256'(data_we), 256'(0));
        chk("arst_cnt", 256'(flush_cnt), 256'(0));
        chk("arst_ready", 256'(in_ready), 256'(0));
        @(posedge clk); #1;
        reset_p = 1'b0;
        idle(1);
        send(16'h0055, 1'b1);
        chk("arst_next_size", 256'(size_o), 256'(1));
        chk("arst_next_data", data_o, 256'(16'h0055));
        idle(1);

        // Randomized bursts with random backpressure
        rnd_en = 1'b1;
        for (int b = 0; b < 60; b++) begin
            int len = $urandom_range(1, 40);
            for (int i = 0; i < len; i++) begin
                send(16'($urandom), i == len - 1);
                if (i != len - 1) idle($urandom_range(0, 2));
            end
            idle($urandom_range(0, 6));
        end
        rnd_en = 1'b0;
        idle(20);
        chk("drain_empty", 256'(exp_q.size()), 256'(0));

        // TIMEOUT=0 instance: no forced flush
        z_valid = 1'b1; z_data = 16'h00A1;
        @(posedge clk); #1;
        z_data = 16'h00A2;
        @(posedge clk); #1;
        z_valid = 1'b0;
        zw = 0;
        repeat (100) begin
            @(negedge clk);
            if (z_we) zw++;
        end
        #1;
        chk("t0_no_flush", 256'(zw), 256'(0));
        chk("t0_ready", 256'(z_ready), 256'(1));
        z_valid = 1'b1; z_last = 1'b1; z_data = 16'h00A3;
        @(posedge clk); #1;
        z_valid = 1'b0; z_last = 1'b0;
        chk("t0_we", 256'(z_we), 256'(1));
        chk("t0_size", 256'(z_size), 256'(3));
        chk("t0_data", z_data_o, 256'(48'h00A3_00A2_00A1));
        idle(1);
        chk("t0_cnt", 256'(z_cnt), 256'(1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/word_packer_256.md
# word_packer_256

Upstream packer for the 256-bit variable-size word FIFO. It accepts a stream of 16-bit words over a valid/ready handshake and gathers up to 16 of them into one 256-bit bus word. It issues that word as a single write with the matching size code: the bus word is full, the source marks the last word of a burst, or the input has been idle too long. It honours the FIFO's `full` flag, so no word is ever dropped or written into a full FIFO.

## Interface
Parameters:
- `TIMEOUT`, 32: idle cycles with a partial word before a forced flush; 0 disables the timeout.

Ports:
- `clk`  in  1  clock; all logic on the rising edge.
- `reset_p`  in  1  reset, asynchronous, active-high (1 - reset).
- `in_data`  in  16  input word.
- `in_valid`  in  1  1 - `in_data` is valid.
- `in_last`  in  1  1 - this word ends a burst; qualified by `in_valid`.
- `in_ready`  out  1  1 - packer accepts a word this cycle.
- `data_o`  out  256  packed words; word k at bits [k*16+15:k*16].
- `size_o`  out  4  number of valid words on `data_o`; 0 means 16.
- `data_we`  out  1  1 - write `data_o`/`size_o` into the FIFO this cycle.
- `full`  in  1  FIFO full flag; 1 blocks `data_we`.
- `flush_cnt`  out  16  number of completed writes, wraps modulo 2^16.

## Operation
- A word is accepted on a rising edge when `in_valid & in_ready` is high.
- State machine, two states:
  - COLLECT: `in_ready`=1. Each accepted word is stored at slot `word_idx`, and `word_idx` (5 bits, 0..16) is incremented.
  - FLUSH: `in_ready`=0. `data_we` = `~full`, combinational from `full`.
- Transitions:
  - COLLECT -> FLUSH on an accepted word that makes `word_idx`=16.
  - COLLECT -> FLUSH on an accepted word with `in_last`=1, whatever the count.
  - COLLECT -> FLUSH when `idle_cnt` reaches `TIMEOUT`-1 with `word_idx`>0 and no word accepted that cycle.
  - FLUSH -> COLLECT on the cycle `data_we`=1.
  - FLUSH holds while `full`=1.
- `size_o` = `word_idx[3:0]`, so 16 encodes as 0. It is valid throughout FLUSH.
- On leaving FLUSH:
  - `word_idx` <- 0.
  - All of `data_o` <- 0. Unused upper slots are therefore always 0.
  - `flush_cnt` increments.
- `idle_cnt` (16 bits, saturating):
  - clears on any accepted word and in FLUSH;
  - counts while in COLLECT with `word_idx`>0;
  - stays 0 while `word_idx`=0.
  - `TIMEOUT`=0 disables the timeout path entirely.
- An empty bus word is never written; FLUSH is always entered with `word_idx`>=1.
- `in_last` on the 16th word causes exactly one write with `size_o`=0, not two.
- `full` may rise during FLUSH. `data_we` drops in the same cycle and `data_o`/`size_o` hold until `full` falls.
- Reset:
  - Asynchronous, any state.
  - State <- COLLECT, `word_idx` <- 0, `idle_cnt` <- 0, `data_o` <- 0, `flush_cnt` <- 0.
  - A partial word is discarded; a pending flush is abandoned.

## Timing
- Reset values: `in_ready`=1 after reset deasserts; `data_we`=0, `size_o`=0, `data_o`=0, `flush_cnt`=0.
- While `reset_p`=1, `in_ready`=0.
- `data_o`, `size_o`, `flush_cnt` and state are registered. `data_we` is state AND `~full`.
- Latency from the accepted word that triggers a flush to `data_we`: 1 cycle (the next cycle) if `full`=0.
- Timeout latency: the last accepted word is at edge N; FLUSH is entered at edge N+`TIMEOUT`; `data_we` is high in the following cycle.
- Throughput: 16 words cost 17 cycles (16 accepts plus 1 flush cycle), because `in_ready` is 0 during FLUSH.
- `data_we` is high for exactly one cycle per write.
- `flush_cnt` updates on the edge that ends that cycle.

## Test plan
- **Full word:** 16 words 0x0001..0x0010 back to back, `full`=0 -> `in_ready` low 1 cycle; one `data_we` pulse with `size_o`=0, `data_o[15:0]`=0x0001, `data_o[255:240]`=0x0010; `flush_cnt`=1.
- **Last marker:** 3 words 0xA, 0xB, 0xC with `in_last` on 0xC -> `data_we` next cycle, `size_o`=3, bits [47:0]=0x000C_000B_000A, bits [255:48]=0.
- **Timeout:** `TIMEOUT`=4, 2 words then `in_valid`=0 -> `data_we` 5 cycles after the 2nd accept, `size_o`=2; with `TIMEOUT`=0 no flush occurs after 100 idle cycles.
- **Backpressure:** `full`=1 when FLUSH is entered, held 10 cycles -> `data_we`=0, `in_ready`=0, `data_o`/`size_o` stable; `full`->0 -> one `data_we`, then `in_ready`=1.
- **Simultaneous last on 16th word:** `in_last` on word 16 -> exactly one write, `size_o`=0; `flush_cnt` +1.
- **Reset mid-operation:** 7 words accepted, then `reset_p` pulsed asynchronously mid-cycle -> outputs 0 immediately, no `data_we`; next 1-word burst with `in_last` -> `size_o`=1 at slot 0.
